pipe_ctrl_unit: RTL and testbench



---
 rtl/pipe_ctrl_unit.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control unit for a 16-bit pipeline: decodes the ID instruction into EX
// control, inserts load-use and flush bubbles, and drains the pipe on HLT.
module pipe_ctrl_unit #(
    parameter int INSTR_W = 16,
    parameter int OPC_W = 4,
    parameter int REG_AW = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h4000,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic              br_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_flag_en,
    output logic              ex_branch,
    output logic              ex_branch_reg,
    output logic              ex_load_upper,
    output logic              ex_pc_save,
    output logic              ex_halt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic regDst;
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic aluSrc;
        logic flagEn;
        logic branch;
        logic branchReg;
        logic loadUpper;
        logic pcSave;
        logic halt;
    } ctrl_t;

    localparam ctrl_t BUBBLE = 13'b0;

    // Opcode-to-control table; a valid bit marks a real instruction.
    function automatic ctrl_t decodeCtrl(input logic [3:0] opc);
        ctrl_t c;
        c = BUBBLE;
        c.valid = 1'b1;
        case (opc)
            4'h0, 4'h1, 4'h2: begin
                c.regDst = 1'b1; c.regWrite = 1'b1; c.flagEn = 1'b1;
            end
            4'h3, 4'h7: begin
                c.regDst = 1'b1; c.regWrite = 1'b1;
            end
            4'h4, 4'h5, 4'h6: begin
                c.aluSrc = 1'b1; c.regDst = 1'b1; c.regWrite = 1'b1; c.flagEn = 1'b1;
            end
            4'h8: begin
                c.aluSrc = 1'b1; c.memRead = 1'b1; c.memToReg = 1'b1;
                c.regWrite = 1'b1; c.regDst = 1'b1;
            end
            4'h9: begin
                c.aluSrc = 1'b1; c.memWrite = 1'b1;
            end
            4'hA: begin
                c.regDst = 1'b1; c.regWrite = 1'b1; c.aluSrc = 1'b1;
            end
            4'hB: begin
                c.regDst = 1'b1; c.regWrite = 1'b1; c.aluSrc = 1'b1; c.loadUpper = 1'b1;
            end
            4'hC: c.branch = 1'b1;
            4'hD: c.branchReg = 1'b1;
            4'hE: begin
                c.pcSave = 1'b1; c.regWrite = 1'b1; c.regDst = 1'b1;
            end
            4'hF: c.halt = 1'b1;
            default: c = BUBBLE;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field names a source register (others use it as an immediate).
    function automatic logic readsRt(input logic [3:0] opc);
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9: readsRt = 1'b1;
            default:                              readsRt = 1'b0;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [3:0]        drainCnt_r, drainCnt_s;
    ctrl_t             exCtrl_r, exCtrl_s;
    logic [REG_AW-1:0] exRd_r, exRd_s;
    logic              stall_s, hazard_s;
    ctrl_t             idCtrl_s;

    logic [3:0]        idOpc_s;
    logic [REG_AW-1:0] idRd_s, idRs_s, idRt_s;

    assign idOpc_s = 4'(id_instr[INSTR_W-1 -: OPC_W]);
    assign idRd_s  = id_instr[INSTR_W-OPC_W-1 -: REG_AW];
    assign idRs_s  = id_instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign idRt_s  = id_instr[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];

    // Decode the ID slot, treating invalid slots and the NOP encoding as bubbles.
    always_comb begin
        if (!id_valid || (id_instr == NOP_INSTR)) begin
            idCtrl_s = BUBBLE;
        end else begin
            idCtrl_s = decodeCtrl(idOpc_s);
        end
    end

    assign hazard_s = exCtrl_r.valid && exCtrl_r.memRead && (exRd_r != '0) && id_valid &&
                      ((exRd_r == idRs_s) || ((exRd_r == idRt_s) && readsRt(idOpc_s)));

    // Next-state, next ID/EX contents and stall, in priority HALTED/DRAIN > flush > load-use.
    always_comb begin
        state_s    = state_r;
        drainCnt_s = drainCnt_r;
        exCtrl_s   = BUBBLE;
        exRd_s     = '0;
        stall_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (br_flush) begin
                    stall_s = 1'b0;
                end else if (hazard_s) begin
                    stall_s = 1'b1;
                end else begin
                    exCtrl_s = idCtrl_s;
                    exRd_s   = idCtrl_s.valid ? idRd_s : '0;
                    if (idCtrl_s.halt) begin
                        state_s    = DRAIN;
                        drainCnt_s = 4'(DRAIN_CYC);
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            DRAIN: begin
                stall_s = 1'b1;
                if (drainCnt_r <= 4'd1) begin
                    state_s    = HALTED;
                    drainCnt_s = 4'd0;
                end else begin
                    drainCnt_s = drainCnt_r - 4'd1;
                end
            end
            HALTED: begin
                stall_s = 1'b1;
            end
            default: begin
                state_s    = RUN;
                drainCnt_s = 4'd0;
            end
        endcase
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = stall_s;
        end
    end

    // ID/EX control register and halt FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            drainCnt_r <= 4'd0;
            exCtrl_r   <= BUBBLE;
            exRd_r     <= '0;
        end else begin
            state_r    <= state_s;
            drainCnt_r <= drainCnt_s;
            exCtrl_r   <= exCtrl_s;
            exRd_r     <= exRd_s;
        end
    end

    assign stall         = stall_s;
    assign halted        = (state_r == HALTED);
    assign ex_valid      = exCtrl_r.valid;
    assign ex_reg_dst    = exCtrl_r.regDst;
    assign ex_reg_write  = exCtrl_r.regWrite;
    assign ex_mem_read   = exCtrl_r.memRead;
    assign ex_mem_write  = exCtrl_r.memWrite;
    assign ex_mem_to_reg = exCtrl_r.memToReg;
    assign ex_alu_src    = exCtrl_r.aluSrc;
    assign ex_flag_en    = exCtrl_r.flagEn;
    assign ex_branch     = exCtrl_r.branch;
    assign ex_branch_reg = exCtrl_r.branchReg;
    assign ex_load_upper = exCtrl_r.loadUpper;
    assign ex_pc_save    = exCtrl_r.pcSave;
    assign ex_halt       = exCtrl_r.halt;
    assign ex_rd         = exRd_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table, load-use, flush, HLT drain and reset.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [15:0] id_instr;
    logic        br_flush;
    logic        stall, halted;
    logic        ex_valid, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_alu_src, ex_flag_en, ex_branch, ex_branch_reg, ex_load_upper, ex_pc_save, ex_halt;
    logic [3:0]  ex_rd;

    int nChecks = 0;
    int nPass = 0;

    // Expected ex_* vectors: valid,regDst,regWrite,memRead,memWrite,memToReg,aluSrc,flagEn,branch,branchReg,loadUpper,pcSave,halt
    localparam logic [12:0] V_NONE = 13'b0000000000000;
    localparam logic [12:0] V_ADD  = 13'b1110000100000;
    localparam logic [12:0] V_RED  = 13'b1110000000000;
    localparam logic [12:0] V_SHF  = 13'b1110001100000;
    localparam logic [12:0] V_LW   = 13'b1111011000000;
    localparam logic [12:0] V_SW   = 13'b1000101000000;
    localparam logic [12:0] V_LLB  = 13'b1110001000000;
    localparam logic [12:0] V_LHB  = 13'b1110001000100;
    localparam logic [12:0] V_B    = 13'b1000000010000;
    localparam logic [12:0] V_BR   = 13'b1000000001000;
    localparam logic [12:0] V_PCS  = 13'b1110000000010;
    localparam logic [12:0] V_HLT  = 13'b1000000000001;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .br_flush(br_flush),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_flag_en(ex_flag_en), .ex_branch(ex_branch),
        .ex_branch_reg(ex_branch_reg), .ex_load_upper(ex_load_upper), .ex_pc_save(ex_pc_save),
        .ex_halt(ex_halt), .ex_rd(ex_rd), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] exVec();
        return {ex_valid, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                ex_alu_src, ex_flag_en, ex_branch, ex_branch_reg, ex_load_upper, ex_pc_save, ex_halt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic fl);
        id_valid = v;
        id_instr = instr;
        br_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put LW r4 into EX.
    task automatic loadR4();
        drive(1'b1, 16'h8410, 1'b0);
        tick();
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [12:0] vec;
        logic [3:0]  rd;
    } vec_t;

    vec_t table_q[$];

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        chk("reset_ex", 32'(exVec()), 32'(V_NONE));
        chk("reset_rd", 32'(ex_rd), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Plain ADD r3,r1,r2
        drive(1'b1, 16'h0312, 1'b0);
        #1 chk("add_stall", 32'(stall), 32'd0);
        tick();
        chk("add_ex", 32'(exVec()), 32'(V_ADD));
        chk("add_rd", 32'(ex_rd), 32'd3);

        // Load-use through rs: one bubble, then issue
        loadR4();
        chk("lw_ex", 32'(exVec()), 32'(V_LW));
        chk("lw_rd", 32'(ex_rd), 32'd4);
        drive(1'b1, 16'h0541, 1'b0);
        #1 chk("lu_rs_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(exVec()), 32'(V_NONE));
        chk("lu_stall_drop", 32'(stall), 32'd0);
        tick();
        chk("lu_issue_ex", 32'(exVec()), 32'(V_ADD));
        chk("lu_issue_rd", 32'(ex_rd), 32'd5);

        // Load-use through rt of an rt-reading opcode
        loadR4();
        drive(1'b1, 16'h0614, 1'b0);
        #1 chk("lu_rt_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_rt_bubble", 32'(exVec()), 32'(V_NONE));

        // SW r4,r2: rt field is 0, rs is r2 -> no hazard
        loadR4();
        drive(1'b1, 16'h9420, 1'b0);
        #1 chk("sw_nostall", 32'(stall), 32'd0);
        tick();
        chk("sw_ex", 32'(exVec()), 32'(V_SW));

        // SRA with r4 in the immediate field -> no hazard
        loadR4();
        drive(1'b1, 16'h5714, 1'b0);
        #1 chk("imm_nostall", 32'(stall), 32'd0);

        // LW r0 followed by a use of r0
        drive(1'b1, 16'h8010, 1'b0);
        tick();
        drive(1'b1, 16'h0500, 1'b0);
        #1 chk("r0_nostall", 32'(stall), 32'd0);
        tick();
        chk("r0_issue", 32'(exVec()), 32'(V_ADD));

        // Flush wins over load-use
        loadR4();
        drive(1'b1, 16'h0541, 1'b1);
        #1 chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_ex", 32'(exVec()), 32'(V_NONE));

        // Invalid slot and NOP are bubbles
        drive(1'b0, 16'h0312, 1'b0);
        tick();
        chk("novalid_ex", 32'(exVec()), 32'(V_NONE));
        drive(1'b1, 16'h4000, 1'b0);
        tick();
        chk("nop_ex", 32'(exVec()), 32'(V_NONE));
        chk("nop_rd", 32'(ex_rd), 32'd0);

        // Remaining decode rows
        table_q.push_back('{16'h3123, V_RED, 4'd1});
        table_q.push_back('{16'h7A12, V_RED, 4'd10});
        table_q.push_back('{16'h5123, V_SHF, 4'd1});
        table_q.push_back('{16'h6F00, V_SHF, 4'd15});
        table_q.push_back('{16'hA2FF, V_LLB, 4'd2});
        table_q.push_back('{16'hB2FF, V_LHB, 4'd2});
        table_q.push_back('{16'hC300, V_B,   4'd3});
        table_q.push_back('{16'hD050, V_BR,  4'd0});
        table_q.push_back('{16'hE700, V_PCS, 4'd7});
        foreach (table_q[i]) begin
            drive(1'b1, table_q[i].instr, 1'b0);
            tick();
            chk($sformatf("dec_%h_ex", table_q[i].instr), 32'(exVec()), 32'(table_q[i].vec));
            chk($sformatf("dec_%h_rd", table_q[i].instr), 32'(ex_rd), 32'(table_q[i].rd));
        end

        // Reset during DRAIN returns straight to RUN
        drive(1'b1, 16'hF000, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 16'h0312, 1'b0);
        #1 chk("drain_rst_stall", 32'(stall), 32'd0);
        tick();
        chk("drain_rst_issue", 32'(exVec()), 32'(V_ADD));

        // HLT: drain for three cycles with flush pulses ignored, then halt
        drive(1'b1, 16'hF000, 1'b0);
        #1 chk("hlt_pre_stall", 32'(stall), 32'd0);
        tick();
        chk("hlt_ex", 32'(exVec()), 32'(V_HLT));
        chk("hlt_halted0", 32'(halted), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'h0312, i[0]);
            #1 chk($sformatf("drain%0d_stall", i), 32'(stall), 32'd1);
            tick();
            chk($sformatf("drain%0d_ex", i), 32'(exVec()), 32'(V_NONE));
            chk($sformatf("drain%0d_halted", i), 32'(halted), (i == 3) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 16'h0312, 1'b1);
        tick();
        chk("halted_stay", 32'(halted), 32'd1);
        chk("halted_stall", 32'(stall), 32'd1);
        chk("halted_ex", 32'(exVec()), 32'(V_NONE));

        // Reset out of HALTED
        rst = 1'b1;
        #1 chk("rst_stall_low", 32'(stall), 32'd0);
        tick();
        chk("rst_halted_clr", 32'(halted), 32'd0);
        rst = 1'b0;
        drive(1'b1, 16'h0312, 1'b0);
        #1 chk("run_stall", 32'(stall), 32'd0);
        tick();
        chk("run_issue", 32'(exVec()), 32'(V_ADD));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
